// File: rtl/uart_rx_frame_check.sv
// -----------------------------------------------------------------------------
// uart_rx_frame_check
//
// UART receive frame checker. It sits between the RX bit sampler and the RX
// deserialiser and consumes one sampled bit per strobe after the start bit.
// It assembles the data word LSB first, checks the optional parity bit
// (even / odd / mark / space) and one or two stop bits. Each frame ends with a
// one-cycle frame_done pulse carrying the per-frame error flags. Sticky flags
// and saturating error counters accumulate results for the register file.
//
// Ports
//   clk            RX clock
//   rst            asynchronous active-low reset
//   frame_start    pulse at the start-bit sample; arms (or re-arms) the checker
//   bit_valid      strobe; sampled_bit is valid this cycle
//   sampled_bit    bit value from the sampler
//   data_len       data bits per frame; 0 or > DATA_WIDTH means DATA_WIDTH
//   par_en         parity bit present
//   par_typ        00 even, 01 odd, 10 mark, 11 space
//   stop_two       two stop bits expected
//   err_clr        clears sticky flags and counters
//   frame_done     one-cycle pulse; frame result valid
//   data_out       received word, unused MSBs 0
//   par_err        parity error of the last frame
//   stp_err        stop error of the last frame
//   par_err_sticky / stp_err_sticky   sticky error flags
//   par_err_cnt    / stp_err_cnt      saturating error counters
// -----------------------------------------------------------------------------
module uart_rx_frame_check #(
  parameter  int DATA_WIDTH = 8,
  parameter  int CNT_WIDTH  = 8,
  localparam int LEN_W      = $clog2(DATA_WIDTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  frame_start,
  input  logic                  bit_valid,
  input  logic                  sampled_bit,
  input  logic [LEN_W-1:0]      data_len,
  input  logic                  par_en,
  input  logic [1:0]            par_typ,
  input  logic                  stop_two,
  input  logic                  err_clr,
  output logic                  frame_done,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  par_err,
  output logic                  stp_err,
  output logic                  par_err_sticky,
  output logic                  stp_err_sticky,
  output logic [CNT_WIDTH-1:0]  par_err_cnt,
  output logic [CNT_WIDTH-1:0]  stp_err_cnt
);

  typedef enum logic [2:0] {
    IDLE,
    DATA,
    PARITY,
    STOP1,
    STOP2,
    DONE
  } state_t;

  typedef enum logic [1:0] {
    PAR_EVEN  = 2'b00,
    PAR_ODD   = 2'b01,
    PAR_MARK  = 2'b10,
    PAR_SPACE = 2'b11
  } par_typ_t;

  state_t     state, state_next;

  // Frame configuration captured at frame_start and held for the whole frame.
  logic [LEN_W-1:0] cfg_len;
  logic             cfg_par_en;
  par_typ_t         cfg_par_typ;
  logic             cfg_stop_two;

  logic [LEN_W-1:0] bit_cnt;
  logic             running_xor;
  logic             par_pend;     // parity verdict waiting for the end of frame
  logic             stp_pend;     // a bad first stop bit waiting for the end of frame
  logic             par_expect;
  logic             last_data;
  logic             load_result;
  logic [LEN_W-1:0] len_eff;

  // Out-of-range lengths fall back to the full data width.
  assign len_eff   = (data_len == '0 || data_len > LEN_W'(DATA_WIDTH)) ?
                     LEN_W'(DATA_WIDTH) : data_len;
  assign last_data = (bit_cnt == cfg_len - LEN_W'(1));

  always_comb begin
    par_expect = 1'b0;
    unique case (cfg_par_typ)
      PAR_EVEN:  par_expect = running_xor;
      PAR_ODD:   par_expect = ~running_xor;
      PAR_MARK:  par_expect = 1'b1;
      PAR_SPACE: par_expect = 1'b0;
    endcase
  end

  // State register.
  // NOTE: clocked state uses non-blocking (<=) so every register samples the
  // pre-edge values of its neighbours; blocking here would create ordering races.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  // Next-state and output decode.
  always_comb begin
    // NOTE: every signal driven here gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    state_next  = state;
    load_result = 1'b0;
    frame_done  = (state == DONE);

    // frame_start wins over everything, including a coincident bit_valid,
    // and re-arms from any state. DONE still reports its result this cycle.
    if (frame_start) begin
      state_next = DATA;
    end else begin
      unique case (state)
        IDLE: ;
        DATA: begin
          if (bit_valid && last_data) state_next = cfg_par_en ? PARITY : STOP1;
        end
        PARITY: begin
          if (bit_valid) state_next = STOP1;
        end
        STOP1: begin
          if (bit_valid) begin
            if (cfg_stop_two) begin
              state_next = STOP2;
            end else begin
              state_next  = DONE;
              load_result = 1'b1;
            end
          end
        end
        STOP2: begin
          if (bit_valid) begin
            state_next  = DONE;
            load_result = 1'b1;
          end
        end
        DONE:    state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  // Frame datapath: shift register, parity accumulation, per-frame results.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cfg_len      <= LEN_W'(DATA_WIDTH);
      cfg_par_en   <= 1'b0;
      cfg_par_typ  <= PAR_EVEN;
      cfg_stop_two <= 1'b0;
      bit_cnt      <= '0;
      running_xor  <= 1'b0;
      par_pend     <= 1'b0;
      stp_pend     <= 1'b0;
      data_out     <= '0;
      par_err      <= 1'b0;
      stp_err      <= 1'b0;
    end else if (frame_start) begin
      cfg_len      <= len_eff;
      cfg_par_en   <= par_en;
      cfg_par_typ  <= par_typ_t'(par_typ);
      cfg_stop_two <= stop_two;
      bit_cnt      <= '0;
      running_xor  <= 1'b0;
      par_pend     <= 1'b0;
      stp_pend     <= 1'b0;
      data_out     <= '0;
      par_err      <= 1'b0;
      stp_err      <= 1'b0;
    end else begin
      if (state == DATA && bit_valid) begin
        data_out    <= data_out | (DATA_WIDTH'(sampled_bit) << bit_cnt);
        running_xor <= running_xor ^ sampled_bit;
        bit_cnt     <= bit_cnt + LEN_W'(1);
      end
      if (state == PARITY && bit_valid) begin
        par_pend <= (sampled_bit != par_expect);
      end
      if ((state == STOP1 || state == STOP2) && bit_valid && !sampled_bit) begin
        stp_pend <= 1'b1;
      end
      // The final stop bit is folded in directly so the result lands on the
      // same edge that enters DONE.
      if (load_result) begin
        par_err <= par_pend;
        stp_err <= stp_pend | ~sampled_bit;
      end
    end
  end

  // Sticky flags and saturating counters; a clear beats a coincident error.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      par_err_sticky <= 1'b0;
      stp_err_sticky <= 1'b0;
      par_err_cnt    <= '0;
      stp_err_cnt    <= '0;
    end else if (err_clr) begin
      par_err_sticky <= 1'b0;
      stp_err_sticky <= 1'b0;
      par_err_cnt    <= '0;
      stp_err_cnt    <= '0;
    end else if (state == DONE) begin
      if (par_err) begin
        par_err_sticky <= 1'b1;
        if (par_err_cnt != '1) par_err_cnt <= par_err_cnt + CNT_WIDTH'(1);
      end
      if (stp_err) begin
        stp_err_sticky <= 1'b1;
        if (stp_err_cnt != '1) stp_err_cnt <= stp_err_cnt + CNT_WIDTH'(1);
      end
    end
  end

endmodule
